clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Multi-channel programmable clock generator, a parametrised successor to the single fixed-divide oscillator model.
- Derives NUM_CH independent divided clock outputs and single-cycle tick strobes from the system clock.
- Adds a global power-up/startup sequence, per-channel glitch-free enable and divisor reprogramming, and a ready flag.
- Sits between the top-level clock source and peripheral blocks that need slow clocks or clock enables.

Parameters:
- NUM_CH, 4: number of output channels (1..16).
- DIV_W, 8: width of each channel divisor.
- DEFAULT_DIV, 0: active divisor of every channel after reset.
- STARTUP_CYCLES, 16: clk cycles spent in STARTUP before RUN (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pu  in  1  global power-up request.
- en  in  NUM_CH  per-channel output enable.
- div_in  in  NUM_CH*DIV_W  divisor values; channel i uses bits [i*DIV_W +: DIV_W].
- div_load  in  NUM_CH  per-channel one-cycle load strobe for div_in slice.
- clk_out  out  NUM_CH  divided clock outputs (registered).
- tick  out  NUM_CH  one-cycle strobe, high in first cycle of each clk_out high phase.
- ready  out  1  high while global state is RUN.

Behaviour:
- Reset (async, rst=1): global state OFF; all cnt=0; clk_out=0; tick=0; ready=0; active_div=DEFAULT_DIV; pending flags cleared.
- Global FSM states: OFF, STARTUP, RUN.
  - OFF to STARTUP when pu=1; startup counter cleared.
  - STARTUP: counter increments each cycle; to RUN on the cycle it reaches STARTUP_CYCLES-1. First RUN cycle follows exactly STARTUP_CYCLES STARTUP cycles.
  - Any state to OFF when pu=0, including mid-STARTUP and mid-RUN.
  - Entering OFF forces all clk_out/tick/cnt to 0 on the next edge. This stop is not glitch-free. active_div and pending values are retained.
- ready is registered and equals (state==RUN).
- Per channel, counting only in RUN:
  - Half-period H = active_div+1 cycles; output period = 2*H cycles, 50% duty. DIV_W=8, div=255 gives period 512.
  - Running channel, each edge: if cnt==active_div then cnt<=0 and clk_out<=~clk_out; otherwise cnt<=cnt+1.
  - tick<=1 exactly on the edge where clk_out goes 0->1, else tick<=0.
- Enable:
  - Channel idle (clk_out=0, cnt=0) and en=1 in RUN: starts counting. First rise occurs H edges after the first edge sampling en=1.
  - en=0 while clk_out=0: channel stops next edge, cnt<=0.
  - en=0 while clk_out=1: high phase completes normally; at the falling toggle the channel goes idle (cnt=0, clk_out=0). No runt pulses.
  - en re-asserted before that fall: channel simply continues.
- Divisor load:
  - div_load[i]=1 captures the slice into pending_div[i] and sets pending flag. A later load before application overwrites it (last wins).
  - Application happens on the first of these edges: an idle edge (channel idle or not in RUN), or a falling toggle (clk_out 1->0). Pending flag clears.
  - The period in progress always finishes with the old divisor.
  - Load on the same edge as a falling toggle: the newly captured value is not applied at that edge; it applies at the next falling toggle.
- Channels are fully independent; there is no cross-channel phase alignment.
- Widths: cnt is DIV_W bits and never exceeds active_div, so there is no wrap. Startup counter is clog2(STARTUP_CYCLES+1) bits.

Test Plan:
- Reset then pu=1 at cycle 0 with STARTUP_CYCLES=16 -> ready rises after exactly 16 STARTUP cycles; all clk_out stay 0 until then.
- RUN, ch0 div=0, en0=1 -> clk_out[0] toggles every cycle (period 2); tick[0] high every other cycle, coincident with each rise.
- ch1 div=3 running; load div=1 mid-high-phase -> current period completes at 8 cycles; subsequent periods are 4 cycles; first change seen after the fall.
- ch2 div=2, drop en2 one cycle into the high phase -> high phase lasts the full 3 cycles, then clk_out stays 0 and cnt=0; re-enable -> first rise 3 edges later.
- Drop pu mid-RUN with all channels active -> next edge all clk_out=0, ready=0. Re-raise pu -> a full 16-cycle STARTUP, then channels resume with retained divisors.
- Assert rst asynchronously mid-period -> outputs 0 immediately (no clock edge); active_div returns to DEFAULT_DIV; pending loads discarded.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock divider with a global
// OFF -> STARTUP -> RUN power-up sequence, per-channel glitch-free enable,
// deferred divisor reprogramming and a ready flag.
module clk_div_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DIV_W          = 8,
    parameter int unsigned DEFAULT_DIV    = 0,
    parameter int unsigned STARTUP_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pu,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*DIV_W-1:0]   div_in,
    input  logic [NUM_CH-1:0]         div_load,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic                      ready
);

    localparam int unsigned SU_W = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SU_W-1:0]  SU_LAST = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_STARTUP,
        ST_RUN
    } state_e;

    state_e                        state_q, state_d;
    logic [SU_W-1:0]               su_cnt_q, su_cnt_d;
    logic                          ready_q, ready_d;

    logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]  act_div_q, act_div_d;
    logic [NUM_CH-1:0][DIV_W-1:0]  pend_div_q, pend_div_d;
    logic [NUM_CH-1:0]             pend_q, pend_d;
    logic [NUM_CH-1:0]             run_q, run_d;
    logic [NUM_CH-1:0]             clk_q, clk_d;
    logic [NUM_CH-1:0]             tick_q, tick_d;
    logic [NUM_CH-1:0]             apply;
    logic                          active;

    // Channels only count while in RUN and power-up is still requested;
    // a pu drop clears every channel on the same edge the FSM goes OFF.
    assign active = (state_q == ST_RUN) && pu;

    // Global power sequencing: next state, startup counter and ready.
    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        if (!pu) begin
            state_d  = ST_OFF;
            su_cnt_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_STARTUP;
                    su_cnt_d = '0;
                end
                ST_STARTUP: begin
                    su_cnt_d = su_cnt_q + 1'b1;
                    if (su_cnt_q == SU_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d  = ST_OFF;
                    su_cnt_d = '0;
                end
            endcase
        end
        ready_d = (state_d == ST_RUN);
    end

    // Per-channel divider: counting, enable handling and divisor hand-over.
    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        run_d      = run_q;
        clk_d      = clk_q;
        tick_d     = '0;
        apply      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!active) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                run_d[i] = 1'b0;
                apply[i] = 1'b1;
            end else if (!run_q[i]) begin
                // Idle: the arming edge only starts the channel, so the
                // first rise lands H edges later like any low phase.
                apply[i] = 1'b1;
                run_d[i] = en[i];
            end else if (!clk_q[i] && !en[i]) begin
                cnt_d[i] = '0;
                run_d[i] = 1'b0;
            end else if (cnt_q[i] == act_div_q[i]) begin
                cnt_d[i] = '0;
                clk_d[i] = ~clk_q[i];
                if (clk_q[i]) begin
                    apply[i] = 1'b1;
                    run_d[i] = en[i];
                end else begin
                    tick_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // Hand-over uses the previously captured value; a load on the
            // same edge only refills the pending slot.
            if (apply[i] && pend_q[i]) begin
                act_div_d[i] = pend_div_q[i];
                pend_d[i]    = 1'b0;
            end
            if (div_load[i]) begin
                pend_d[i]     = 1'b1;
                pend_div_d[i] = div_in[i*DIV_W +: DIV_W];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            su_cnt_q   <= '0;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            act_div_q  <= {NUM_CH{DEF_DIV}};
            pend_div_q <= '0;
            pend_q     <= '0;
            run_q      <= '0;
            clk_q      <= '0;
            tick_q     <= '0;
        end else begin
            state_q    <= state_d;
            su_cnt_q   <= su_cnt_d;
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            run_q      <= run_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed scenarios plus randomized traffic,
// checked every cycle against an edge-scheduling reference model.
module tb_clk_div_bank;

    localparam int NUM_CH         = 4;
    localparam int DIV_W          = 8;
    localparam int DEFAULT_DIV    = 1;
    localparam int STARTUP_CYCLES = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pu;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic                    ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH        (NUM_CH),
        .DIV_W         (DIV_W),
        .DEFAULT_DIV   (DEFAULT_DIV),
        .STARTUP_CYCLES(STARTUP_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pu      (pu),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .clk_out (clk_out),
        .tick    (tick),
        .ready   (ready)
    );

    // Reference model: global phase 0=OFF 1=STARTUP 2=RUN; each running
    // channel stores the absolute edge number of its next toggle.
    int m_phase, m_run_at, m_n;
    bit m_run [NUM_CH];
    bit m_high[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_pend[NUM_CH];
    int m_next[NUM_CH];
    int m_div [NUM_CH];
    int m_pval[NUM_CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_run_at = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 0; m_high[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
            m_next[i] = 0; m_div[i] = DEFAULT_DIV; m_pval[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit act, apply, arm;
        logic [DIV_W-1:0] sl;
        act = (m_phase == 2) && (pu === 1'b1);
        m_n++;
        if (pu !== 1'b1) m_phase = 0;
        else if (m_phase == 0) begin m_phase = 1; m_run_at = m_n + STARTUP_CYCLES; end
        else if (m_phase == 1 && m_n == m_run_at) m_phase = 2;
        for (int i = 0; i < NUM_CH; i++) begin
            apply = 0; arm = 0; m_tick[i] = 0;
            if (!act) begin
                m_run[i] = 0; m_high[i] = 0; apply = 1;
            end else if (!m_run[i]) begin
                apply = 1;
                if (en[i]) begin m_run[i] = 1; arm = 1; end
            end else if (!m_high[i] && !en[i]) begin
                m_run[i] = 0;
            end else if (m_n == m_next[i]) begin
                if (m_high[i]) begin
                    m_high[i] = 0; apply = 1;
                    if (en[i]) arm = 1; else m_run[i] = 0;
                end else begin
                    m_high[i] = 1; m_tick[i] = 1;
                    m_next[i] = m_n + m_div[i] + 1;
                end
            end
            if (apply && m_pend[i]) begin m_div[i] = m_pval[i]; m_pend[i] = 0; end
            if (arm) m_next[i] = m_n + m_div[i] + 1;
            if (div_load[i]) begin
                sl = div_in[i*DIV_W +: DIV_W];
                m_pend[i] = 1; m_pval[i] = int'(sl);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_edge();
    end

    task automatic compare_all();
        logic [NUM_CH-1:0] ec, et;
        for (int i = 0; i < NUM_CH; i++) begin ec[i] = m_high[i]; et[i] = m_tick[i]; end
        check_val("clk_out", 32'(clk_out), 32'(ec));
        check_val("tick", 32'(tick), 32'(et));
        check_val("ready", 32'(ready), 32'(m_phase == 2));
    endtask

    // Runs k cycles from a negedge, checking after each rising edge and
    // dropping any load strobe after one cycle.
    task automatic cyc(input int k);
        for (int c = 0; c < k; c++) begin
            @(posedge clk);
            #1 compare_all();
            @(negedge clk);
            div_load = '0;
        end
    endtask

    task automatic load_ch(input int ch, input int val);
        div_load[ch] = 1'b1;
        div_in[ch*DIV_W +: DIV_W] = DIV_W'(val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, t0, t1, cnt;
        model_reset();
        m_n = 0;
        rst = 1'b1; pu = 1'b0; en = '0; div_load = '0; div_in = '0;
        #12 compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Power-up: ready after exactly STARTUP_CYCLES STARTUP cycles.
        pu = 1'b1;
        w = 0;
        while (!ready && w < 40) begin cyc(1); w++; end
        check_val("startup_len", 32'(w), 32'(STARTUP_CYCLES + 1));

        // ch0 at div 0: period 2.
        load_ch(0, 0); cyc(2);
        en[0] = 1'b1;
        cyc(3);
        w = 0;
        while (!tick[0] && w < 10) begin cyc(1); w++; end
        cyc(1); cnt = 1;
        while (!tick[0] && cnt < 10) begin cyc(1); cnt++; end
        check_val("ch0_period", 32'(cnt), 32'd2);

        // ch1: div 3, reprogram to 1 during the high phase.
        load_ch(1, 3); cyc(2);
        en[1] = 1'b1;
        cyc(10);
        w = 0;
        while (!clk_out[1] && w < 20) begin cyc(1); w++; end
        check_val("ch1_high_seen", 32'(w < 20), 32'd1);
        cyc(1);
        load_ch(1, 1);
        cyc(30);

        // ch2: div 2, drop en one cycle into the high phase, then re-enable.
        load_ch(2, 2); cyc(2);
        en[2] = 1'b1;
        w = 0;
        while (!tick[2] && w < 20) begin cyc(1); w++; end
        check_val("ch2_rise_seen", 32'(w < 20), 32'd1);
        en[2] = 1'b0;
        cyc(8);
        en[2] = 1'b1;
        cyc(12);

        // ch3: div 255 gives a 512-cycle period.
        load_ch(3, 255); cyc(2);
        en[3] = 1'b1;
        cnt = 0; t0 = -1; t1 = -1;
        while (t1 < 0 && cnt < 1600) begin
            cyc(1); cnt++;
            if (tick[3]) begin if (t0 < 0) t0 = cnt; else t1 = cnt; end
        end
        check_val("ch3_period", 32'(t1 - t0), 32'd512);
        load_ch(3, 2); cyc(1100);

        // pu drop mid-RUN, then a full restart with retained divisors.
        en = '1;
        cyc(5);
        pu = 1'b0;
        cyc(1);
        check_val("pu_drop_clk", 32'(clk_out), 32'd0);
        cyc(3);
        pu = 1'b1;
        cyc(40);

        // Async reset mid-period with a pending load that must be discarded.
        w = 0;
        while (!clk_out[1] && w < 20) begin cyc(1); w++; end
        load_ch(0, 7);
        cyc(1);
        #2 rst = 1'b1;
        #1 compare_all();
        check_val("rst_async_clk", 32'(clk_out), 32'd0);
        check_val("rst_async_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(60);

        // Randomized traffic.
        for (int r = 0; r < 1500; r++) begin
            if (pu) begin
                if ($urandom_range(0, 399) == 0) pu = 1'b0;
            end else if ($urandom_range(0, 3) == 0) pu = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
                if ($urandom_range(0, 15) == 0) load_ch(i, int'($urandom_range(0, 6)));
            end
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
